doa_peak_search: RTL and testbench
==================================

# doa_peak_search

Downstream stage of the beamformer power computation. Sweeps a steering-angle index and presents it upstream so the steering vector can be selected. Accumulates the beam power |y|² over a fixed number of snapshots per angle, then tracks the angle with the largest accumulated power across the sweep. Reports the peak angle and its power once per sweep, for the DoA estimate consumed by the control/readout logic.

## Interface
- `P_WIDTH`, 55: width of the unsigned incoming power word, matching 2·(2·12+3)+1 bits for 12-bit samples.
- `N_ANGLES`, 181: number of steering angles per sweep, indices 0..N_ANGLES-1.
- `ANG_WIDTH`, 8: width of the angle index; must satisfy 2^ANG_WIDTH ≥ N_ANGLES.
- `LOG2_SNAP`, 4: log2 of snapshots accumulated per angle; NSNAP = 2^LOG2_SNAP.
- `ACC_WIDTH`, P_WIDTH+LOG2_SNAP: accumulator and peak-power width. This width cannot overflow.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE.
- `pwr_data`, in, P_WIDTH: unsigned power value from the |.|² stage.
- `pwr_valid`, in, 1: `pwr_data` is valid.
- `pwr_ready`, out, 1: block accepts a beat. A beat transfers when `pwr_valid` and `pwr_ready` are both high.
- `ang_idx`, out, ANG_WIDTH: angle currently being measured; drives the upstream steering-vector select.
- `busy`, out, 1: high from the cycle after `start` is accepted until DONE is left.
- `peak_valid`, out, 1: one-cycle pulse when a sweep completes.
- `peak_idx`, out, ANG_WIDTH: angle of the maximum from the last completed sweep.
- `peak_pwr`, out, ACC_WIDTH: accumulated power at `peak_idx`.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including `peak_idx` and `peak_pwr`.
  - Internal `acc`, `snap`, `best_pwr` and `best_idx` are cleared.
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- IDLE:
  - `pwr_ready`=0, `busy`=0.
  - `start`=1 moves to ACCUM and clears `ang_idx`, `snap`, `acc`, `best_pwr` and `best_idx`.
- ACCUM:
  - `pwr_ready`=1.
  - Each transfer adds `pwr_data` (zero-extended) to `acc` and increments `snap`.
  - The transfer with `snap`==NSNAP-1 moves to COMPARE.
  - Cycles without `pwr_valid` change nothing.
- COMPARE (exactly 1 cycle, `pwr_ready`=0):
  - If `ang_idx`==0 or `acc` > `best_pwr` (strict), load `best_pwr`←`acc` and `best_idx`←`ang_idx`. Ties therefore keep the lowest index.
  - Clear `acc` and `snap`.
  - If `ang_idx`==N_ANGLES-1, go to DONE. Otherwise increment `ang_idx` and go to ACCUM.
- DONE (exactly 1 cycle):
  - `peak_valid`=1; `peak_idx`←`best_idx`, `peak_pwr`←`best_pwr`.
  - Go to IDLE.
  - `peak_idx` and `peak_pwr` hold until the next DONE or reset. They are not disturbed during a sweep.
- `ang_idx` stays at N_ANGLES-1 after a sweep until the next `start`.
- `start` outside IDLE is ignored and not queued.
- Reset in the middle of a sweep abandons it: no `peak_valid`, and previous results are cleared to 0.
- Arithmetic is unsigned only. There is no saturation; ACC_WIDTH guarantees exactness.

## Timing
- `pwr_ready` is a registered function of state only; it does not depend on `pwr_valid` combinationally.
- `ang_idx` changes only on the COMPARE→ACCUM edge. Upstream has one bubble cycle (COMPARE) to switch the steering vector.
- `peak_valid` rises 2 cycles after the edge that accepts the final beat (COMPARE, then DONE).
- Minimum sweep length with `pwr_valid` held high: N_ANGLES·(NSNAP+1)+1 cycles from `start` to `peak_valid`.
- `busy` rises the cycle after `start` and falls the cycle after DONE.

## Structure
- Shared package `doa_pkg` holds:
  - the P_WIDTH/ANG_WIDTH/LOG2_SNAP defaults;
  - the ACC_WIDTH derivation;
  - the FSM state enum (IDLE/ACCUM/COMPARE/DONE).
- One sub-module, `doa_pwr_accum`:
  - snapshot accumulator plus counter with clear and add-enable;
  - outputs `acc` and `last_beat`.
- The FSM and max tracker stay in the top level.

## Test plan
Benches use N_ANGLES=4, LOG2_SNAP=1 unless stated.
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0, `pwr_ready`=0; `start` during reset does not start a sweep.
- **Single peak:** per-angle beats {10,10},{5,5},{100,1},{7,7} → `peak_valid` pulse, `peak_idx`=2, `peak_pwr`=101.
- **Tie:** all 8 beats =8 → `peak_idx`=0, `peak_pwr`=16. Monotonic {1,1},{2,2},{3,3},{4,4} → `peak_idx`=3, `peak_pwr`=8.
- **Backpressure and order:** toggle `pwr_valid` randomly and pulse `start` mid-sweep → same result as the single-peak case; `ang_idx` steps 0,1,2,3 only after COMPARE; exactly one `peak_valid`.
- **Width:** all beats = 2^P_WIDTH-1 → `peak_pwr`=2·(2^P_WIDTH-1) exactly, `peak_idx`=0.
- **Mid-sweep reset:** assert reset after angle 1 compares → no `peak_valid`, `peak_idx`=`peak_pwr`=0; the next `start` completes a normal sweep.

Source files
------------

// File: rtl/doa_pkg.sv
// Shared defaults, width derivation and FSM state type for the DoA peak search.
package doa_pkg;

  localparam int unsigned P_WIDTH_D   = 55;
  localparam int unsigned N_ANGLES_D  = 181;
  localparam int unsigned ANG_WIDTH_D = 8;
  localparam int unsigned LOG2_SNAP_D = 4;

  // Summing 2^log2_snap words of p bits needs exactly log2_snap extra bits.
  function automatic int unsigned acc_width(input int unsigned p, input int unsigned log2_snap);
    return p + log2_snap;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/doa_pwr_accum.sv
// Per-angle snapshot accumulator with beat counter; flags the final beat of an angle.
module doa_pwr_accum
  import doa_pkg::*;
#(
  parameter int unsigned P_WIDTH   = P_WIDTH_D,
  parameter int unsigned LOG2_SNAP = LOG2_SNAP_D,
  parameter int unsigned ACC_WIDTH = acc_width(P_WIDTH, LOG2_SNAP)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_add,
  input  logic [P_WIDTH-1:0]   i_data,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_last_beat
);

  localparam int unsigned SNAP_W = (LOG2_SNAP > 0) ? LOG2_SNAP : 1;
  localparam logic [SNAP_W-1:0] SNAP_LAST = SNAP_W'((1 << LOG2_SNAP) - 1);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [SNAP_W-1:0]    r_snap;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else if (i_add) begin
      r_acc  <= r_acc + ACC_WIDTH'(i_data);
      r_snap <= o_last_beat ? '0 : r_snap + 1'b1;
    end
  end

  assign o_acc       = r_acc;
  assign o_last_beat = (r_snap == SNAP_LAST);

endmodule

// File: rtl/doa_peak_search.sv
// Angle sweep controller: accumulates beam power per steering angle and reports the peak.
module doa_peak_search
  import doa_pkg::*;
#(
  parameter int unsigned P_WIDTH   = P_WIDTH_D,
  parameter int unsigned N_ANGLES  = N_ANGLES_D,
  parameter int unsigned ANG_WIDTH = ANG_WIDTH_D,
  parameter int unsigned LOG2_SNAP = LOG2_SNAP_D,
  parameter int unsigned ACC_WIDTH = acc_width(P_WIDTH, LOG2_SNAP)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [P_WIDTH-1:0]   pwr_data,
  input  logic                 pwr_valid,
  output logic                 pwr_ready,
  output logic [ANG_WIDTH-1:0] ang_idx,
  output logic                 busy,
  output logic                 peak_valid,
  output logic [ANG_WIDTH-1:0] peak_idx,
  output logic [ACC_WIDTH-1:0] peak_pwr
);

  localparam logic [ANG_WIDTH-1:0] ANG_LAST = ANG_WIDTH'(N_ANGLES - 1);

  state_t               r_state, w_state_nxt;
  logic [ANG_WIDTH-1:0] r_ang_idx, r_best_idx, r_peak_idx;
  logic [ACC_WIDTH-1:0] r_best_pwr, r_peak_pwr;
  logic [ACC_WIDTH-1:0] w_acc;
  logic                 w_last_beat, w_add, w_clr, w_take, w_last_ang;

  assign w_add      = (r_state == ST_ACCUM) && pwr_valid;
  assign w_clr      = ((r_state == ST_IDLE) && start) || (r_state == ST_COMPARE);
  assign w_last_ang = (r_ang_idx == ANG_LAST);
  assign w_take     = (r_ang_idx == '0) || (w_acc > r_best_pwr);

  doa_pwr_accum #(
    .P_WIDTH  (P_WIDTH),
    .LOG2_SNAP(LOG2_SNAP),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_add      (w_add),
    .i_data     (pwr_data),
    .o_acc      (w_acc),
    .o_last_beat(w_last_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_ACCUM;
      ST_ACCUM:   if (pwr_valid && w_last_beat) w_state_nxt = ST_COMPARE;
      ST_COMPARE: w_state_nxt = w_last_ang ? ST_DONE : ST_ACCUM;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // The final compare forwards its winner straight into the peak registers so
  // peak_idx/peak_pwr are already updated during the DONE pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ang_idx  <= '0;
      r_best_idx <= '0;
      r_best_pwr <= '0;
      r_peak_idx <= '0;
      r_peak_pwr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ang_idx  <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
          end
        end
        ST_COMPARE: begin
          if (w_take) begin
            r_best_pwr <= w_acc;
            r_best_idx <= r_ang_idx;
          end
          if (w_last_ang) begin
            r_peak_idx <= w_take ? r_ang_idx : r_best_idx;
            r_peak_pwr <= w_take ? w_acc : r_best_pwr;
          end else begin
            r_ang_idx <= r_ang_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pwr_ready  = (r_state == ST_ACCUM);
  assign busy       = (r_state != ST_IDLE);
  assign peak_valid = (r_state == ST_DONE);
  assign ang_idx    = r_ang_idx;
  assign peak_idx   = r_peak_idx;
  assign peak_pwr   = r_peak_pwr;

endmodule

// File: tb/tb_doa_peak_search.sv
// Self-checking bench for doa_peak_search with 4 angles and 2 snapshots per angle.
module tb_doa_peak_search;

  localparam int unsigned P_W   = 55;
  localparam int unsigned NA    = 4;
  localparam int unsigned ANG_W = 8;
  localparam int unsigned L2    = 1;
  localparam int unsigned NSNAP = 1 << L2;
  localparam int unsigned ACC_W = P_W + L2;
  localparam int unsigned NB    = NA * NSNAP;
  localparam int unsigned MIN_SWEEP = NA * (NSNAP + 1) + 1;

  typedef logic [NB-1:0][P_W-1:0] beats_t;

  typedef struct {
    beats_t             beats;
    int unsigned        exp_idx;
    logic [ACC_W-1:0]   exp_pwr;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [P_W-1:0]   pwr_data;
  logic             pwr_valid;
  logic             pwr_ready;
  logic [ANG_W-1:0] ang_idx;
  logic             busy;
  logic             peak_valid;
  logic [ANG_W-1:0] peak_idx;
  logic [ACC_W-1:0] peak_pwr;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  doa_peak_search #(
    .P_WIDTH  (P_W),
    .N_ANGLES (NA),
    .ANG_WIDTH(ANG_W),
    .LOG2_SNAP(L2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pwr_data  (pwr_data),
    .pwr_valid (pwr_valid),
    .pwr_ready (pwr_ready),
    .ang_idx   (ang_idx),
    .busy      (busy),
    .peak_valid(peak_valid),
    .peak_idx  (peak_idx),
    .peak_pwr  (peak_pwr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beats_t mk(input longint unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    beats_t b;
    b[0] = P_W'(a0); b[1] = P_W'(a1); b[2] = P_W'(a2); b[3] = P_W'(a3);
    b[4] = P_W'(a4); b[5] = P_W'(a5); b[6] = P_W'(a6); b[7] = P_W'(a7);
    return b;
  endfunction

  // Reference: per-angle sums, global maximum, then the lowest angle reaching it.
  function automatic void model(input beats_t b, output int unsigned idx, output logic [ACC_W-1:0] pwr);
    logic [ACC_W-1:0] sums [NA];
    logic [ACC_W-1:0] mx = '0;
    for (int a = 0; a < NA; a++) begin
      sums[a] = '0;
      for (int s = 0; s < NSNAP; s++) sums[a] += ACC_W'(b[a*NSNAP + s]);
      if (sums[a] > mx) mx = sums[a];
    end
    idx = 0;
    for (int a = NA - 1; a >= 0; a--) if (sums[a] == mx) idx = a;
    pwr = mx;
  endfunction

  task automatic run_sweep(input beats_t b, input bit gaps, input bit mids,
                           input int unsigned eidx, input logic [ACC_W-1:0] epwr, input int tag);
    int unsigned      k = 0, cyc = 0, extra = 0;
    bit               pv = 0, disturbed = 0, ang_ok = 1, v;
    logic [ANG_W-1:0] pidx0, got_idx = '0;
    logic [ACC_W-1:0] ppwr0, got_pwr = '0;
    string            t;
    t = $sformatf("sweep%0d", tag);
    @(negedge clk);
    pidx0 = peak_idx;
    ppwr0 = peak_pwr;
    start = 1'b1;
    while (!pv && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (peak_valid) begin
        pv = 1;
        got_idx = peak_idx;
        got_pwr = peak_pwr;
        chk({t, ".busy_done"}, 64'(busy), 64'd1);
      end else if (peak_idx !== pidx0 || peak_pwr !== ppwr0) begin
        disturbed = 1;
      end
      if (k < NB) begin
        v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        pwr_valid = v;
        pwr_data  = v ? b[k] : P_W'({$urandom(), $urandom()});
        if (v && pwr_ready) begin
          if (ang_idx !== ANG_W'(k / NSNAP)) ang_ok = 0;
          k++;
        end
      end else begin
        pwr_valid = 1'b0;
      end
      start = (mids && k < NB && cyc > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    pwr_valid = 1'b0;
    start = 1'b0;
    chk({t, ".peak_seen"}, 64'(pv), 64'd1);
    chk({t, ".peak_idx"}, 64'(got_idx), 64'(eidx));
    chk({t, ".peak_pwr"}, 64'(got_pwr), 64'(epwr));
    chk({t, ".beats"}, 64'(k), 64'(NB));
    chk({t, ".ang_order"}, 64'(ang_ok), 64'd1);
    chk({t, ".hold_during"}, 64'(disturbed), 64'd0);
    if (!gaps) chk({t, ".latency"}, 64'(cyc), 64'(MIN_SWEEP));
    @(negedge clk);
    chk({t, ".busy_after"}, 64'(busy), 64'd0);
    chk({t, ".ang_after"}, 64'(ang_idx), 64'(NA - 1));
    for (int i = 0; i < 4; i++) begin
      if (peak_valid) extra++;
      @(negedge clk);
    end
    chk({t, ".one_pulse"}, 64'(extra), 64'd0);
    chk({t, ".hold_idx"}, 64'(peak_idx), 64'(eidx));
    chk({t, ".hold_pwr"}, 64'(peak_pwr), 64'(epwr));
  endtask

  vec_t             tbl [5];
  beats_t           rb;
  int unsigned      midx;
  logic [ACC_W-1:0] mpwr;
  int unsigned      cyc, pv_cnt;

  initial begin
    rst_n = 1'b0; start = 1'b1; pwr_valid = 1'b0; pwr_data = '0;

    tbl[0].beats = mk(10, 10, 5, 5, 100, 1, 7, 7);   tbl[0].exp_idx = 2; tbl[0].exp_pwr = 101;
    tbl[1].beats = mk(8, 8, 8, 8, 8, 8, 8, 8);       tbl[1].exp_idx = 0; tbl[1].exp_pwr = 16;
    tbl[2].beats = mk(1, 1, 2, 2, 3, 3, 4, 4);       tbl[2].exp_idx = 3; tbl[2].exp_pwr = 8;
    for (int i = 0; i < NB; i++) tbl[3].beats[i] = '1;
    tbl[3].exp_idx = 0; tbl[3].exp_pwr = 56'hFFFFFFFFFFFFFE;
    tbl[4].beats = mk(3, 4, 0, 7, 6, 1, 2, 2);       tbl[4].exp_idx = 0; tbl[4].exp_pwr = 7;

    repeat (3) @(negedge clk);
    chk("rst.pwr_ready", 64'(pwr_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.peak_valid", 64'(peak_valid), 64'd0);
    chk("rst.ang_idx", 64'(ang_idx), 64'd0);
    chk("rst.peak_idx", 64'(peak_idx), 64'd0);
    chk("rst.peak_pwr", 64'(peak_pwr), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.no_start", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++)
      run_sweep(tbl[i].beats, 1'b0, 1'b0, tbl[i].exp_idx, tbl[i].exp_pwr, i);

    run_sweep(tbl[0].beats, 1'b1, 1'b1, 2, 101, 10);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NB; i++)
        rb[i] = $urandom_range(0, 1) ? P_W'($urandom_range(0, 6)) : P_W'({$urandom(), $urandom()});
      model(rb, midx, mpwr);
      run_sweep(rb, r[0], r[1], midx, mpwr, 20 + r);
    end

    // Abandon a sweep right after angle 1 has been compared.
    run_sweep(tbl[0].beats, 1'b0, 1'b0, 2, 101, 30);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pwr_valid = 1'b1;
    pwr_data = P_W'(50);
    cyc = 0;
    pv_cnt = 0;
    while (ang_idx != 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (peak_valid) pv_cnt++;
    end
    chk("midrst.reach_ang2", 64'(ang_idx), 64'd2);
    rst_n = 1'b0;
    pwr_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (peak_valid) pv_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (peak_valid) pv_cnt++;
    end
    chk("midrst.no_pulse", 64'(pv_cnt), 64'd0);
    chk("midrst.peak_idx", 64'(peak_idx), 64'd0);
    chk("midrst.peak_pwr", 64'(peak_pwr), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.ang_idx", 64'(ang_idx), 64'd0);
    run_sweep(tbl[2].beats, 1'b0, 1'b0, 3, 8, 31);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
